// File: rtl/stk_pipe_al.sv
// Free-list allocator for stack line pointers: a circular FIFO of free pointers,
// seeded with 0..PTRS_N-1 by an init sweep after reset, then popped by AD and refilled by deallocs.
package stk_pkg;
    localparam int PTRS_N_DEF = 64;
    typedef logic [$clog2(PTRS_N_DEF)-1:0] ptr_t;
endpackage

module stk_pipe_al #(
    parameter int PTRS_N = 64,
    parameter int PTR_W  = $clog2(PTRS_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ad_alloc,
    output logic             o_ad_empty_r,
    output logic             o_ad_busy_r,
    output logic [PTR_W-1:0] o_lk_ptr_w,
    input  logic             i_dealloc_vld,
    input  logic [PTR_W-1:0] i_dealloc_ptr,
    output logic [PTR_W:0]   o_free_cnt_r,
    output logic             o_err_r
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PTRS_N);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(PTRS_N - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   init_idx_q, init_idx_d;
    logic [PTR_W-1:0]   rd_idx_q, rd_idx_d;
    logic [PTR_W-1:0]   wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               empty_q, empty_d;
    logic               err_q, err_d;

    logic [PTR_W-1:0]   mem_q [PTRS_N];
    logic               mem_we;
    logic [PTR_W-1:0]   mem_waddr;
    logic [PTR_W-1:0]   mem_wdata;

    logic               alloc_ok;
    logic               dealloc_ok;
    logic               dup_free;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        empty_d    = empty_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_idx_q;
        mem_wdata  = i_dealloc_ptr;
        alloc_ok   = 1'b0;
        dealloc_ok = 1'b0;
        case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_idx_q;
                mem_wdata  = init_idx_q;
                init_idx_d = init_idx_q + 1'b1;
                if (i_ad_alloc || i_dealloc_vld)
                    err_d = 1'b1;
                // The edge that writes the last entry hands over a completely full list.
                if (init_idx_q == LAST) begin
                    state_d  = RUN;
                    cnt_d    = FULL;
                    rd_idx_d = '0;
                    wr_idx_d = '0;
                    busy_d   = 1'b0;
                    empty_d  = 1'b0;
                end
            end
            RUN: begin
                alloc_ok   = i_ad_alloc && (cnt_q != '0);
                dealloc_ok = i_dealloc_vld && (cnt_q != FULL);
                if ((i_ad_alloc && !alloc_ok) || (i_dealloc_vld && !dealloc_ok))
                    err_d = 1'b1;
                if (alloc_ok)
                    rd_idx_d = rd_idx_q + 1'b1;
                if (dealloc_ok) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                end
                case ({alloc_ok, dealloc_ok})
                    2'b10:   cnt_d = cnt_q - 1'b1;
                    2'b01:   cnt_d = cnt_q + 1'b1;
                    default: cnt_d = cnt_q;
                endcase
                empty_d = (cnt_d == '0);
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            empty_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            empty_q    <= empty_d;
            err_q      <= err_d;
        end
    end

    // Storage carries no reset; the init sweep rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign o_lk_ptr_w   = mem_q[rd_idx_q];
    assign o_free_cnt_r = cnt_q;
    assign o_ad_empty_r = empty_q;
    assign o_ad_busy_r  = busy_q;
    assign o_err_r      = err_q;

    // Scan of the live window rd_idx..rd_idx+cnt-1, only observed by the checks below.
    always_comb begin
        dup_free = 1'b0;
        for (int i = 0; i < PTRS_N; i++)
            if ((CNT_W'(i) < cnt_q) && (mem_q[rd_idx_q + PTR_W'(i)] == i_dealloc_ptr))
                dup_free = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                assert (!(i_ad_alloc || i_dealloc_vld))
                    else $warning("request during init sweep");
            end else begin
                assert (!(i_ad_alloc && cnt_q == '0))
                    else $warning("alloc while empty");
                assert (!(i_dealloc_vld && cnt_q == FULL))
                    else $warning("dealloc while full");
                assert (!(i_ad_alloc && i_dealloc_vld && cnt_q == '0))
                    else $warning("alloc with dealloc while empty");
                assert (!(dealloc_ok && dup_free))
                    else $warning("duplicate free of pointer %0d", i_dealloc_ptr);
            end
        end
    end
endmodule

// File: tb/tb_stk_pipe_al.sv
// Randomised and directed checks of stk_pipe_al against a queue-based free-list model.
module tb_stk_pipe_al;
    localparam int N = 64;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         alloc = 1'b0;
    logic         dvld = 1'b0;
    logic [W-1:0] dptr = '0;
    logic         empty, busy, err;
    logic [W-1:0] lk;
    logic [W:0]   fcnt;

    int checks = 0;
    int errors = 0;
    int q[$];     // free list, head at index 0
    int outq[$];  // pointers currently held by the requester

    always #5 clk = ~clk;

    stk_pipe_al #(.PTRS_N(N)) dut (
        .clk(clk), .rst(rst),
        .i_ad_alloc(alloc), .o_ad_empty_r(empty), .o_ad_busy_r(busy),
        .o_lk_ptr_w(lk), .i_dealloc_vld(dvld), .i_dealloc_ptr(dptr),
        .o_free_cnt_r(fcnt), .o_err_r(err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Legal requests only are applied; alloc takes the head before the dealloc is appended.
    function automatic void model_step(bit a, bit d, int p);
        bit a_ok = a && q.size() > 0;
        bit d_ok = d && q.size() < N;
        if (a_ok) outq.push_back(q.pop_front());
        if (d_ok) q.push_back(p);
    endfunction

    task automatic reset_and_init(output int cyc);
        @(negedge clk);
        rst = 1'b1; alloc = 1'b0; dvld = 1'b0;
        tick(); tick();
        rst = 1'b0;
        q.delete(); outq.delete();
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < N; i++) q.push_back(i);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (fcnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fcnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    endtask

    task automatic test_init();
        int cyc;
        reset_and_init(cyc);
        checks++; if (cyc != N) begin errors++; $display("FAIL init_cycles got %0d exp %0d", cyc, N); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL init_empty got %0b exp 0", empty); end
        checks++; if (fcnt !== (W+1)'(N)) begin errors++; $display("FAIL init_cnt got %0d exp %0d", fcnt, N); end
        checks++; if (lk !== '0) begin errors++; $display("FAIL init_head got %0d exp 0", lk); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err got %0b exp 0", err); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < N; i++) begin
            alloc = 1'b1;
            checks++; if (lk !== W'(i)) begin errors++; $display("FAIL drain_grant got %0d exp %0d", lk, i); end
            tick();
            model_step(1'b1, 1'b0, 0);
        end
        alloc = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", empty); end
        checks++; if (fcnt !== '0) begin errors++; $display("FAIL drain_cnt got %0d exp 0", fcnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err got %0b exp 0", err); end
    endtask

    task automatic test_fifo_order();
        int p[3] = '{5, 9, 2};
        for (int k = 0; k < 3; k++) begin
            dvld = 1'b1; dptr = W'(p[k]);
            foreach (outq[j]) if (outq[j] == p[k]) begin outq.delete(j); break; end
            tick();
            dvld = 1'b0;
            model_step(1'b0, 1'b1, p[k]);
            checks++; if (fcnt !== (W+1)'(k + 1)) begin errors++; $display("FAIL fifo_fill_cnt got %0d exp %0d", fcnt, k + 1); end
        end
        for (int k = 0; k < 3; k++) begin
            alloc = 1'b1;
            checks++; if (lk !== W'(p[k])) begin errors++; $display("FAIL fifo_grant got %0d exp %0d", lk, p[k]); end
            tick();
            alloc = 1'b0;
            model_step(1'b1, 1'b0, 0);
            checks++; if (fcnt !== (W+1)'(2 - k)) begin errors++; $display("FAIL fifo_drain_cnt got %0d exp %0d", fcnt, 2 - k); end
        end
    endtask

    task automatic test_simul();
        foreach (outq[j]) if (outq[j] == 7) begin outq.delete(j); break; end
        dvld = 1'b1; dptr = W'(7);
        tick();
        dvld = 1'b0;
        model_step(1'b0, 1'b1, 7);
        checks++; if (lk !== W'(7)) begin errors++; $display("FAIL simul_head7 got %0d exp 7", lk); end
        foreach (outq[j]) if (outq[j] == 12) begin outq.delete(j); break; end
        alloc = 1'b1; dvld = 1'b1; dptr = W'(12);
        checks++; if (lk !== W'(7)) begin errors++; $display("FAIL simul_grant got %0d exp 7", lk); end
        tick();
        alloc = 1'b0; dvld = 1'b0;
        model_step(1'b1, 1'b1, 12);
        checks++; if (fcnt !== (W+1)'(1)) begin errors++; $display("FAIL simul_cnt got %0d exp 1", fcnt); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty got %0b exp 0", empty); end
        checks++; if (lk !== W'(12)) begin errors++; $display("FAIL simul_head12 got %0d exp 12", lk); end
        alloc = 1'b1;
        tick();
        alloc = 1'b0;
        model_step(1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit a, d;
            int p = 0;
            a = ($urandom_range(0, 1) == 1) && q.size() > 0;
            d = ($urandom_range(0, 1) == 1) && outq.size() > 0 && q.size() < N;
            if (d) begin
                int idx = $urandom_range(0, outq.size() - 1);
                p = outq[idx];
                outq.delete(idx);
            end
            alloc = a; dvld = d; dptr = W'(p);
            if (a) begin
                checks++; if (lk !== W'(q[0])) begin errors++; $display("FAIL rand_grant got %0d exp %0d", lk, q[0]); end
            end
            tick();
            alloc = 1'b0; dvld = 1'b0;
            model_step(a, d, p);
            checks++; if (fcnt !== (W+1)'(q.size())) begin errors++; $display("FAIL rand_cnt got %0d exp %0d", fcnt, q.size()); end
            checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty got %0b exp %0b", empty, q.size() == 0); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err got %0b exp 0", err); end
        end
    endtask

    task automatic test_err_empty();
        int cyc;
        reset_and_init(cyc);
        checks++; if (cyc != N) begin errors++; $display("FAIL erre_init got %0d exp %0d", cyc, N); end
        alloc = 1'b1;
        for (int i = 0; i < N; i++) tick();
        alloc = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL erre_pre got %0b exp 0", err); end
        alloc = 1'b1;
        tick();
        alloc = 1'b0;
        checks++; if (fcnt !== '0) begin errors++; $display("FAIL erre_cnt got %0d exp 0", fcnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL erre_empty got %0b exp 1", empty); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL erre_sticky got %0b exp 1", err); end
            tick();
        end
        // alloc+dealloc while empty: only the dealloc lands
        alloc = 1'b1; dvld = 1'b1; dptr = W'(33);
        tick();
        alloc = 1'b0; dvld = 1'b0;
        checks++; if (fcnt !== (W+1)'(1)) begin errors++; $display("FAIL erre_both_cnt got %0d exp 1", fcnt); end
        checks++; if (lk !== W'(33)) begin errors++; $display("FAIL erre_both_head got %0d exp 33", lk); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL erre_both_err got %0b exp 1", err); end
    endtask

    task automatic test_err_full();
        int cyc;
        reset_and_init(cyc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL errf_cleared got %0b exp 0", err); end
        dvld = 1'b1; dptr = W'(5);
        tick();
        dvld = 1'b0;
        checks++; if (fcnt !== (W+1)'(N)) begin errors++; $display("FAIL errf_cnt got %0d exp %0d", fcnt, N); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL errf_err got %0b exp 1", err); end
        checks++; if (lk !== '0) begin errors++; $display("FAIL errf_head got %0d exp 0", lk); end
    endtask

    task automatic test_err_init();
        int cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); cyc++; end
        alloc = 1'b1;
        tick(); cyc++;
        alloc = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL erri_err got %0b exp 1", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL erri_busy got %0b exp 1", busy); end
        while (busy === 1'b1 && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc != N) begin errors++; $display("FAIL erri_cycles got %0d exp %0d", cyc, N); end
        checks++; if (fcnt !== (W+1)'(N)) begin errors++; $display("FAIL erri_cnt got %0d exp %0d", fcnt, N); end
        checks++; if (lk !== '0) begin errors++; $display("FAIL erri_head got %0d exp 0", lk); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL erri_sticky got %0b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        reset_and_init(cyc);
        alloc = 1'b1;
        for (int i = 0; i < 34; i++) tick();
        alloc = 1'b0;
        checks++; if (fcnt !== (W+1)'(30)) begin errors++; $display("FAIL rmid_pre got %0d exp 30", fcnt); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0b exp 1", busy); end
        checks++; if (fcnt !== '0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", fcnt); end
        rst = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc != N) begin errors++; $display("FAIL rmid_cycles got %0d exp %0d", cyc, N); end
        checks++; if (lk !== '0) begin errors++; $display("FAIL rmid_head got %0d exp 0", lk); end
        checks++; if (fcnt !== (W+1)'(N)) begin errors++; $display("FAIL rmid_cnt_full got %0d exp %0d", fcnt, N); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_drain();
        test_fifo_order();
        test_simul();
        test_random();
        test_err_empty();
        test_err_full();
        test_err_init();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
